// File: rtl/painterengine_gpu_dma_reader_pkg.sv
// PainterEngine GPU shared definitions.
// DMA reader state codes and AXI/word constants.
package painterengine_gpu_pkg;

  typedef enum logic [7:0] {
    RD_IDLE        = 8'h00,
    RD_CHECK       = 8'h01,
    RD_AR          = 8'h02,
    RD_R           = 8'h03,
    RD_PUSH        = 8'h04,
    RD_DONE        = 8'h05,
    RD_DRAIN_AR    = 8'h06,
    RD_DRAIN_R     = 8'h07,
    RD_ALIGN_ERROR = 8'h08,
    RD_BUS_ERROR   = 8'h09
  } rd_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] WORD_BYTES    = 32'd4;

endpackage

// File: rtl/painterengine_gpu_dma_reader_if.sv
// DMA reader port group: task control, AXI4-Lite read
// master, staging FIFO write side and state readback.
interface painterengine_gpu_dma_reader_if;

  logic        i_wire_dma_reader_resetn;
  logic [31:0] i_wire_dma_reader_address;
  logic [31:0] i_wire_dma_reader_length;
  logic        o_wire_dma_reader_done;
  logic        o_wire_dma_reader_error;

  logic [31:0] o_wire_m_araddr;
  logic        o_wire_m_arvalid;
  logic        i_wire_m_arready;
  logic [31:0] i_wire_m_rdata;
  logic [1:0]  i_wire_m_rresp;
  logic        i_wire_m_rvalid;
  logic        o_wire_m_rready;

  logic [31:0] o_wire_fifo_data;
  logic        o_wire_fifo_write;
  logic        i_wire_fifo_full;

  logic [31:0] o_wire_state;

  modport master (
    input  i_wire_dma_reader_resetn,
    input  i_wire_dma_reader_address,
    input  i_wire_dma_reader_length,
    output o_wire_dma_reader_done,
    output o_wire_dma_reader_error,
    output o_wire_m_araddr,
    output o_wire_m_arvalid,
    input  i_wire_m_arready,
    input  i_wire_m_rdata,
    input  i_wire_m_rresp,
    input  i_wire_m_rvalid,
    output o_wire_m_rready,
    output o_wire_fifo_data,
    output o_wire_fifo_write,
    input  i_wire_fifo_full,
    output o_wire_state
  );

  modport slave (
    output i_wire_dma_reader_resetn,
    output i_wire_dma_reader_address,
    output i_wire_dma_reader_length,
    input  o_wire_dma_reader_done,
    input  o_wire_dma_reader_error,
    input  o_wire_m_araddr,
    input  o_wire_m_arvalid,
    output i_wire_m_arready,
    output i_wire_m_rdata,
    output i_wire_m_rresp,
    output i_wire_m_rvalid,
    input  o_wire_m_rready,
    input  o_wire_fifo_data,
    input  o_wire_fifo_write,
    output i_wire_fifo_full,
    input  o_wire_state
  );

endinterface

// File: rtl/painterengine_gpu_dma_reader.sv
// Memory-to-FIFO DMA read engine, one AXI4-Lite read
// outstanding, one block per enable pulse.
module painterengine_gpu_dma_reader
  import painterengine_gpu_pkg::*;
(
  input logic i_wire_clock,
  input logic i_wire_resetn,
  painterengine_gpu_dma_reader_if.master bus
);

  rd_state_e   state_q;
  rd_state_e   state_d;
  logic [31:0] cur_addr_q;
  logic [31:0] remaining_q;
  logic [31:0] word_q;
  logic        write_q;

  logic en;
  logic misaligned;
  logic push_ok;

  assign en         = bus.i_wire_dma_reader_resetn;
  assign misaligned = (|cur_addr_q[1:0]) | (|remaining_q[1:0]);
  // Strobe is registered so fifo_full never reaches an output.
  assign push_ok    = (state_q == RD_PUSH) & en & ~bus.i_wire_fifo_full;

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) state_q <= RD_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:
        if (en) state_d = RD_CHECK;
      RD_CHECK:
        if (!en)                     state_d = RD_IDLE;
        else if (misaligned)         state_d = RD_ALIGN_ERROR;
        else if (remaining_q == '0)  state_d = RD_DONE;
        else                         state_d = RD_AR;
      RD_AR:
        if (bus.i_wire_m_arready) state_d = en ? RD_R : RD_DRAIN_R;
        else if (!en)             state_d = RD_DRAIN_AR;
      RD_R:
        if (bus.i_wire_m_rvalid) begin
          if (!en)
            state_d = RD_IDLE;
          else if (bus.i_wire_m_rresp != AXI_RESP_OKAY)
            state_d = RD_BUS_ERROR;
          else
            state_d = RD_PUSH;
        end else if (!en) begin
          state_d = RD_DRAIN_R;
        end
      RD_PUSH:
        if (!en)                        state_d = RD_IDLE;
        else if (!bus.i_wire_fifo_full) state_d = RD_CHECK;
      RD_DONE, RD_ALIGN_ERROR, RD_BUS_ERROR:
        if (!en) state_d = RD_IDLE;
      // VALID already raised must complete; enable is ignored here.
      RD_DRAIN_AR:
        if (bus.i_wire_m_arready) state_d = RD_DRAIN_R;
      RD_DRAIN_R:
        if (bus.i_wire_m_rvalid) state_d = RD_IDLE;
      default:
        state_d = RD_IDLE;
    endcase
  end

  logic arvalid_c;
  logic rready_c;
  logic done_c;
  logic error_c;

  always_comb begin
    arvalid_c = 1'b0;
    rready_c  = 1'b0;
    done_c    = 1'b0;
    error_c   = 1'b0;
    unique case (state_q)
      RD_AR, RD_DRAIN_AR:           arvalid_c = 1'b1;
      RD_R, RD_DRAIN_R:             rready_c  = 1'b1;
      RD_DONE:                      done_c    = 1'b1;
      RD_ALIGN_ERROR, RD_BUS_ERROR: error_c   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      write_q     <= 1'b0;
    end else begin
      write_q <= push_ok;
      if (state_q == RD_IDLE && en) begin
        cur_addr_q  <= bus.i_wire_dma_reader_address;
        remaining_q <= bus.i_wire_dma_reader_length;
      end
      if (state_q == RD_R && bus.i_wire_m_rvalid)
        word_q <= bus.i_wire_m_rdata;
      if (push_ok) begin
        cur_addr_q  <= cur_addr_q + WORD_BYTES;
        remaining_q <= remaining_q - WORD_BYTES;
      end
    end
  end

  assign bus.o_wire_m_araddr         = cur_addr_q;
  assign bus.o_wire_m_arvalid        = arvalid_c;
  assign bus.o_wire_m_rready         = rready_c;
  assign bus.o_wire_dma_reader_done  = done_c;
  assign bus.o_wire_dma_reader_error = error_c;
  assign bus.o_wire_fifo_data        = word_q;
  assign bus.o_wire_fifo_write       = write_q;
  assign bus.o_wire_state            = {24'd0, state_q};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for the DMA reader: AXI slave model, FIFO
// scoreboard, vector table plus stall/drain sequences.
module tb_painterengine_gpu_dma_reader;
  import painterengine_gpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  painterengine_gpu_dma_reader_if bus();

  painterengine_gpu_dma_reader dut (
    .i_wire_clock  (clk),
    .i_wire_resetn (rst_n),
    .bus           (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          err_beat;
    bit          exp_done;
    bit          exp_err;
    logic [7:0]  exp_state;
    int          exp_cyc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  int n_writes = 0;
  int n_ar     = 0;
  int n_r      = 0;
  int ar_stall = 0;
  int err_beat = -1;
  int beat     = 0;

  logic        s_pending = 1'b0;
  logic        s_last_arv = 1'b0;
  logic        s_last_rr = 1'b0;
  logic [31:0] s_last_addr = '0;
  logic [31:0] s_paddr = '0;
  logic        s_ar_hs;
  logic        s_r_hs;

  vec_t vecs[8];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI4-Lite slave: decides arready/rvalid at each falling edge.
  initial begin
    bus.i_wire_m_arready = 1'b0;
    bus.i_wire_m_rvalid  = 1'b0;
    bus.i_wire_m_rdata   = '0;
    bus.i_wire_m_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      s_ar_hs = s_last_arv & bus.i_wire_m_arready;
      s_r_hs  = s_last_rr & bus.i_wire_m_rvalid;
      if (!rst_n) begin
        s_pending = 1'b0;
        s_ar_hs   = 1'b0;
        s_r_hs    = 1'b0;
      end
      if (s_last_arv && bus.o_wire_m_arvalid && !s_ar_hs)
        check("araddr_stable", bus.o_wire_m_araddr, s_last_addr);
      if (s_ar_hs) begin
        s_pending = 1'b1;
        s_paddr   = s_last_addr;
        n_ar++;
      end
      if (s_r_hs) begin
        s_pending = 1'b0;
        n_r++;
        beat++;
      end
      bus.i_wire_m_arready = 1'b0;
      if (bus.o_wire_m_arvalid && !s_pending) begin
        if (ar_stall > 0) ar_stall--;
        else bus.i_wire_m_arready = 1'b1;
      end
      bus.i_wire_m_rvalid = s_pending;
      bus.i_wire_m_rdata  = s_pending ? mem_word(s_paddr) : '0;
      bus.i_wire_m_rresp  = (s_pending && beat == err_beat) ? 2'b10 : 2'b00;
      s_last_arv  = bus.o_wire_m_arvalid;
      s_last_rr   = bus.o_wire_m_rready;
      s_last_addr = bus.o_wire_m_araddr;
    end
  end

  // FIFO side scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_wire_fifo_write) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fifo_unexpected: got write %h expected none",
                   bus.o_wire_fifo_data);
        end else begin
          check("fifo_data", bus.o_wire_fifo_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_vec(vec_t v, string tag);
    int  w0 = n_writes;
    int  a0 = n_ar;
    int  nb = int'(v.len >> 2);
    bit  al = (v.addr[1:0] == 2'b00) && (v.len[1:0] == 2'b00);
    int  ew;
    int  ea;
    int  cyc = 0;
    bit  ok = 0;
    ew = !al ? 0 : (v.err_beat < 0 ? nb : v.err_beat);
    ea = !al ? 0 : (v.err_beat < 0 ? nb : v.err_beat + 1);
    for (int i = 0; i < ew; i++)
      exp_q.push_back(mem_word(v.addr + 32'(i * 4)));
    err_beat = v.err_beat;
    beat = 0;
    @(negedge clk);
    bus.i_wire_dma_reader_address = v.addr;
    bus.i_wire_dma_reader_length  = v.len;
    bus.i_wire_dma_reader_resetn  = 1'b1;
    while (cyc < 200 && !ok) begin
      @(negedge clk);
      cyc++;
      if (bus.o_wire_dma_reader_done || bus.o_wire_dma_reader_error)
        ok = 1;
    end
    check({tag, "_finished"}, 32'(ok), 32'd1);
    check({tag, "_cycles"}, 32'(cyc), 32'(v.exp_cyc));
    check({tag, "_done"}, 32'(bus.o_wire_dma_reader_done), 32'(v.exp_done));
    check({tag, "_error"}, 32'(bus.o_wire_dma_reader_error), 32'(v.exp_err));
    check({tag, "_state"}, bus.o_wire_state, {24'd0, v.exp_state});
    check({tag, "_writes"}, 32'(n_writes - w0), 32'(ew));
    check({tag, "_ar_count"}, 32'(n_ar - a0), 32'(ea));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.i_wire_dma_reader_resetn = 1'b0;
    @(negedge clk);
    check({tag, "_clr_done"}, 32'(bus.o_wire_dma_reader_done), 32'd0);
    check({tag, "_clr_error"}, 32'(bus.o_wire_dma_reader_error), 32'd0);
    check({tag, "_clr_state"}, bus.o_wire_state, 32'd0);
  endtask

  initial begin
    int cyc;
    int w0;
    int a0;
    int r0;
    bit ok;

    vecs[0] = '{32'h0000_1000, 32'd16, -1, 1, 0, 8'h05, 18};
    vecs[1] = '{32'h0000_2000, 32'd0,  -1, 1, 0, 8'h05, 2};
    vecs[2] = '{32'h0000_1002, 32'd16, -1, 0, 1, 8'h08, 2};
    vecs[3] = '{32'h0000_1000, 32'd6,  -1, 0, 1, 8'h08, 2};
    vecs[4] = '{32'h0000_3000, 32'd16,  1, 0, 1, 8'h09, 8};
    vecs[5] = '{32'hFFFF_FFF8, 32'd16, -1, 1, 0, 8'h05, 18};
    vecs[6] = '{32'h0000_0040, 32'd4,   0, 0, 1, 8'h09, 4};
    vecs[7] = '{32'h0000_0100, 32'd4,  -1, 1, 0, 8'h05, 6};

    bus.i_wire_dma_reader_resetn  = 1'b0;
    bus.i_wire_dma_reader_address = '0;
    bus.i_wire_dma_reader_length  = '0;
    bus.i_wire_fifo_full          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", bus.o_wire_state, 32'd0);
    check("rst_arvalid", 32'(bus.o_wire_m_arvalid), 32'd0);
    check("rst_rready", 32'(bus.o_wire_m_rready), 32'd0);
    check("rst_write", 32'(bus.o_wire_fifo_write), 32'd0);
    check("rst_done", 32'(bus.o_wire_dma_reader_done), 32'd0);
    check("rst_error", 32'(bus.o_wire_dma_reader_error), 32'd0);
    check("rst_araddr", bus.o_wire_m_araddr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // FIFO full for 10 cycles while holding a word.
    w0 = n_writes;
    err_beat = -1;
    beat = 0;
    exp_q.push_back(mem_word(32'h0000_5000));
    exp_q.push_back(mem_word(32'h0000_5004));
    bus.i_wire_fifo_full = 1'b1;
    @(negedge clk);
    bus.i_wire_dma_reader_address = 32'h0000_5000;
    bus.i_wire_dma_reader_length  = 32'd8;
    bus.i_wire_dma_reader_resetn  = 1'b1;
    cyc = 0;
    ok = 0;
    while (cyc < 50 && !ok) begin
      @(negedge clk);
      cyc++;
      if (bus.o_wire_state == 32'd4) ok = 1;
    end
    check("full_reach_push", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_no_write", 32'(bus.o_wire_fifo_write), 32'd0);
      check("full_hold_push", bus.o_wire_state, 32'd4);
    end
    bus.i_wire_fifo_full = 1'b0;
    @(negedge clk);
    check("full_release_write", 32'(bus.o_wire_fifo_write), 32'd1);
    cyc = 0;
    ok = 0;
    while (cyc < 50 && !ok) begin
      @(negedge clk);
      cyc++;
      if (bus.o_wire_dma_reader_done) ok = 1;
    end
    check("full_done", 32'(ok), 32'd1);
    check("full_writes", 32'(n_writes - w0), 32'd2);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.i_wire_dma_reader_resetn = 1'b0;
    @(negedge clk);
    check("full_clr_state", bus.o_wire_state, 32'd0);

    // Enable dropped during a stalled address phase.
    w0 = n_writes;
    a0 = n_ar;
    r0 = n_r;
    ar_stall = 5;
    @(negedge clk);
    bus.i_wire_dma_reader_address = 32'h0000_6000;
    bus.i_wire_dma_reader_length  = 32'd8;
    bus.i_wire_dma_reader_resetn  = 1'b1;
    cyc = 0;
    ok = 0;
    while (cyc < 20 && !ok) begin
      @(negedge clk);
      cyc++;
      if (bus.o_wire_m_arvalid) ok = 1;
    end
    check("drain_arvalid_seen", 32'(ok), 32'd1);
    bus.i_wire_dma_reader_resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_arvalid_held", 32'(bus.o_wire_m_arvalid), 32'd1);
      check("drain_ar_state", bus.o_wire_state, 32'd6);
    end
    cyc = 0;
    ok = 0;
    while (cyc < 30 && !ok) begin
      @(negedge clk);
      cyc++;
      if (bus.o_wire_state == 32'd0) ok = 1;
    end
    check("drain_to_idle", 32'(ok), 32'd1);
    check("drain_ar_count", 32'(n_ar - a0), 32'd1);
    check("drain_r_count", 32'(n_r - r0), 32'd1);
    check("drain_no_write", 32'(n_writes - w0), 32'd0);
    repeat (2) @(negedge clk);

    run_vec('{32'h0000_7000, 32'd8, -1, 1, 0, 8'h05, 10}, "after_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
